// File: rtl/sra_mc_pkg.sv
// Shared ALU constants: datapath/shift-amount widths and shifter FSM encoding.
package alu_pkg;
  localparam int WIDTH = 32;
  localparam int SHW   = 5;
  localparam int KW    = $clog2(SHW);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;
endpackage

// File: rtl/sra_mc_if.sv
// Processor-to-shifter handshake bundle; master is the core, slave is the shifter.
interface sra_mc_if
  import alu_pkg::*;
();
  logic             ctrl_start;
  logic [WIDTH-1:0] data_operandA;
  logic [SHW-1:0]   ctrl_shamt;
  logic             ctrl_arith;
  logic [WIDTH-1:0] data_result;
  logic             data_resultRDY;
  logic             data_busy;

  modport master (
    output ctrl_start, data_operandA, ctrl_shamt, ctrl_arith,
    input  data_result, data_resultRDY, data_busy
  );

  modport slave (
    input  ctrl_start, data_operandA, ctrl_shamt, ctrl_arith,
    output data_result, data_resultRDY, data_busy
  );
endinterface

// File: rtl/sra_mc_sr_stage.sv
// One combinational barrel stage: optional right shift by 2^k with a fill bit.
module sr_stage
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] in,
  input  logic [KW-1:0]    k,
  input  logic             en,
  input  logic             fill,
  output logic [WIDTH-1:0] out
);
  always_comb begin
    out = in;
    if (en) begin
      for (int j = 0; j < SHW; j++) begin
        // Vacated top 2^j bits are taken from the fill mask.
        if (k == KW'(j))
          out = (in >> (1 << j)) | ({WIDTH{fill}} & ~({WIDTH{1'b1}} >> (1 << j)));
      end
    end
  end
endmodule

// File: rtl/sra_mc.sv
// Multi-cycle SRL/SRA: one barrel stage per clock, result 5 edges after accept.
// Busy during SHIFT; one-cycle RDY pulse in DONE, where a new start may be accepted.
module sra_mc
  import alu_pkg::*;
(
  input  logic     clock,
  input  logic     reset_n,
  sra_mc_if.slave  bus
);
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_shamt;
  logic             r_arith;
  logic             r_sign;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_result;
  logic             r_rdy;
  logic             r_busy;

  logic [WIDTH-1:0] w_stage;
  logic             w_accept;

  // IDLE, DONE and the unused encoding all accept a start.
  assign w_accept = bus.ctrl_start && (r_state != ST_SHIFT);

  sr_stage u_stage (
    .in   (r_work),
    .k    (r_k),
    .en   (r_shamt[r_k]),
    .fill (r_sign & r_arith),
    .out  (w_stage)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_work   <= '0;
      r_shamt  <= '0;
      r_arith  <= 1'b0;
      r_sign   <= 1'b0;
      r_k      <= '0;
      r_result <= '0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (r_state == ST_SHIFT) begin
        r_work <= w_stage;
        if (r_k == '0) begin
          r_result <= w_stage;
          r_rdy    <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= ST_DONE;
        end else begin
          r_k <= r_k - 1'b1;
        end
      end else if (w_accept) begin
        r_work  <= bus.data_operandA;
        r_shamt <= bus.ctrl_shamt;
        r_arith <= bus.ctrl_arith;
        r_sign  <= bus.data_operandA[WIDTH-1];
        r_k     <= KW'(SHW - 1);
        r_busy  <= 1'b1;
        r_state <= ST_SHIFT;
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_resultRDY = r_rdy;
  assign bus.data_busy      = r_busy;
endmodule

// File: doc/sra_mc.md
# sra_mc

Multi-cycle right shifter for the ALU shift path, complementing the existing combinational left shifter. It implements SRL and SRA using a five-stage barrel network, evaluating one stage per clock under a start/ready handshake. Area is one 32-bit register and one stage mux instead of five mux levels in the critical path. The processor stalls on `data_busy` and picks up the result on `data_resultRDY`, the same way it does for multdiv.

## Interface
- `WIDTH`, default 32: datapath width; must be a power of two.
- `SHW`, default 5: shift-amount width, equal to log2(`WIDTH`).
- `clock` in 1: the single clock; all state changes on its rising edge.
- `reset_n` in 1: reset, synchronous and active-low.
- `ctrl_start` in 1: request a shift; sampled only when the block is not busy.
- `data_operandA` in WIDTH: value to shift; latched when a start is accepted.
- `ctrl_shamt` in SHW: shift amount 0..31; latched when a start is accepted.
- `ctrl_arith` in 1: 1 selects SRA (sign fill); 0 selects SRL (zero fill). Latched when a start is accepted.
- `data_result` out WIDTH: last completed result, held until the next completion.
- `data_resultRDY` out 1: one-cycle pulse marking the cycle in which `data_result` is new.
- `data_busy` out 1: high while a shift is in progress.

## Operation
- **States:** IDLE, SHIFT, DONE.
- **Start acceptance:** a start is accepted when `ctrl_start`=1 and the state is IDLE or DONE. On acceptance the block latches the operand into the work register, the shamt, the arith flag, and sign = `data_operandA[31]`. It then sets stage counter k=SHW-1 and goes to SHIFT.
- **SHIFT, each cycle:**
  - If `shamt[k]`=1, work = work >> 2^k, with the vacated top 2^k bits filled with `sign & arith`. Otherwise work is unchanged.
  - When k=0: `data_result` <= stage output, go to DONE. Otherwise k <= k-1.
- **DONE:**
  - Lasts exactly one cycle; `data_resultRDY`=1.
  - Goes to SHIFT if a start is accepted, otherwise to IDLE.
- **Start while busy:** `ctrl_start` during SHIFT is ignored and not queued.
- **Zero shift:** shamt=0 still takes the full latency, and the result equals the operand.
- **Sign source:** the fill bit comes from the latched original sign, never from the live work register.
- **Mid-operation input changes:** changes on the inputs during SHIFT have no effect.
- **Reset** (`reset_n`=0 at a rising edge), including mid-operation:
  - state IDLE;
  - `data_result`=0, `data_resultRDY`=0, `data_busy`=0;
  - the in-flight operation is discarded and no RDY pulse is produced for it;
  - reset wins over a simultaneous `ctrl_start`.

## Timing
- Let E0 be the edge that accepts a start.
- Stages 4,3,2,1,0 are applied at E1..E5.
- `data_busy`=1 from after E0 until E5; `data_busy`=0 after E5.
- `data_resultRDY`=1 for exactly the one cycle between E5 and E6, and `data_result` is valid from E5.
- Latency is 5 cycles from the accepting edge to the result.
- Back-to-back operation: a start presented during the DONE cycle is accepted at E6. Peak throughput is one result per 6 cycles.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- **Shared package (`alu_pkg`):** `WIDTH`, `SHW`, and the state encoding constants `ST_IDLE`=2'b00, `ST_SHIFT`=2'b01, `ST_DONE`=2'b10. The unused encoding 2'b11 is treated as IDLE.
- **Sub-module `sr_stage`:** combinational, one barrel stage. Ports: `in`, `k`, `en`, `fill`, `out`. It computes `out` = `en` ? {2^k copies of `fill`, `in[31:2^k]`} : `in`, selecting among the 5 fixed shift distances by `k`. It is instantiated once; the top level holds the FSM, counter and registers.

## Test plan
- **Reset:** hold `reset_n`=0 for 2 cycles, then release. Require `data_result`=0, RDY=0 and busy=0, and no RDY pulse over the following 10 idle cycles.
- **SRL and SRA of 0x80000000 by 4:** SRL gives 0x08000000, with RDY exactly 5 edges after acceptance. SRA gives 0xF8000000.
- **Extremes by 31:**
  - SRA of 0xFFFFFFFF gives 0xFFFFFFFF.
  - SRA of 0x7FFFFFFF gives 0x00000000.
  - SRL of 0xFFFFFFFF gives 0x00000001.
  - shamt 0 on 0x12345678 gives 0x12345678 after the full 5 cycles.
- **Handshake:**
  - Start SRL 0xF0000000 by 8. Pulse `ctrl_start` at cycle 2 with a different operand; it must be ignored, and the result is 0x00F00000.
  - A start issued in the DONE cycle gives a second RDY exactly 6 cycles after the first.
- **Reset mid-operation:** assert reset at E3 of a shift. Require no RDY pulse, `data_result`=0, and a correct result for a new start issued after release.
- **Random regression:** 1000 random operand/shamt/arith triples, compared against a `>>`/`>>>` reference model.
